// File: rtl/csr_irq_ctrl.sv
// Machine-mode CSR file and interrupt controller: level/edge interrupt lines,
// fixed-priority trap entry, mret stacking, direct/vectored mtvec and a 64-bit mcycle.
module csr_irq_ctrl #(
    parameter int                   BUS_WIDTH     = 32,
    parameter int                   NUM_IRQ       = 4,
    parameter int                   IRQ_BASE_CODE = 16,
    parameter logic [NUM_IRQ-1:0]   IRQ_EDGE      = '0,
    parameter logic [BUS_WIDTH-1:0] MTVEC_RESET   = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 csr_rd_en,
    input  logic                 csr_wr_en,
    input  logic [1:0]           csr_op,
    input  logic [11:0]          csr_addr,
    input  logic [BUS_WIDTH-1:0] csr_wdata,
    output logic [BUS_WIDTH-1:0] csr_rdata,
    input  logic [NUM_IRQ-1:0]   irq_src,
    input  logic                 stage_valid,
    input  logic [BUS_WIDTH-1:0] inst_pc,
    input  logic                 is_mret,
    output logic                 redirect,
    output logic [BUS_WIDTH-1:0] redirect_pc
);
    localparam logic [11:0] A_MSTATUS = 12'h300;
    localparam logic [11:0] A_MIE     = 12'h304;
    localparam logic [11:0] A_MTVEC   = 12'h305;
    localparam logic [11:0] A_MEPC    = 12'h341;
    localparam logic [11:0] A_MCAUSE  = 12'h342;
    localparam logic [11:0] A_MIP     = 12'h344;
    localparam logic [11:0] A_MCYCLE  = 12'hB00;
    localparam logic [11:0] A_MCYCLEH = 12'hB80;

    typedef enum logic {ST_IDLE, ST_FLUSH} state_t;
    state_t r_state, w_state_nxt;

    logic                 r_mie, r_mpie;
    logic [NUM_IRQ-1:0]   r_irq_en, r_mip, r_irq_prev;
    logic [BUS_WIDTH-3:0] r_mtvec_base;
    logic                 r_mtvec_vec;
    logic [BUS_WIDTH-1:0] r_mepc;
    logic                 r_mcause_int;
    logic [4:0]           r_mcause_code;
    logic [BUS_WIDTH-1:0] r_cyc_lo, r_cyc_hi;

    logic [NUM_IRQ-1:0]     w_pend;
    logic [4:0]             w_idx, w_cause;
    logic                   w_idle, w_trap, w_mret, w_wr;
    logic [BUS_WIDTH-1:0]   w_old, w_new, w_base;
    logic [2*BUS_WIDTH-1:0] w_cyc_inc;

    assign w_pend    = r_mip & r_irq_en;
    assign w_idle    = (r_state == ST_IDLE);
    assign w_mret    = w_idle && stage_valid && is_mret;
    assign w_trap    = w_idle && (|w_pend) && r_mie && stage_valid && !is_mret;
    assign w_cause   = 5'(IRQ_BASE_CODE) + w_idx;
    assign w_base    = {r_mtvec_base, 2'b00};
    assign w_wr      = csr_wr_en && (csr_op != 2'b00) && !w_trap;
    assign w_cyc_inc = {r_cyc_hi, r_cyc_lo} + (2*BUS_WIDTH)'(1);
    assign csr_rdata = csr_rd_en ? w_old : '0;

    // Lowest-numbered pending line has the highest priority.
    always_comb begin
        w_idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (w_pend[i]) w_idx = 5'(i);
        end
    end

    always_comb begin
        w_old = '0;
        case (csr_addr)
            A_MSTATUS: begin
                w_old[3]     = r_mie;
                w_old[7]     = r_mpie;
                w_old[12:11] = 2'b11;
            end
            A_MIE:     for (int i = 0; i < NUM_IRQ; i++) w_old[IRQ_BASE_CODE+i] = r_irq_en[i];
            A_MIP:     for (int i = 0; i < NUM_IRQ; i++) w_old[IRQ_BASE_CODE+i] = r_mip[i];
            A_MTVEC:   w_old = {r_mtvec_base, 1'b0, r_mtvec_vec};
            A_MEPC:    w_old = r_mepc;
            A_MCAUSE:  w_old = {r_mcause_int, {(BUS_WIDTH-6){1'b0}}, r_mcause_code};
            A_MCYCLE:  w_old = r_cyc_lo;
            A_MCYCLEH: w_old = r_cyc_hi;
            default:   w_old = '0;
        endcase
    end

    always_comb begin
        case (csr_op)
            2'b01:   w_new = csr_wdata;
            2'b10:   w_new = w_old | csr_wdata;
            2'b11:   w_new = w_old & ~csr_wdata;
            default: w_new = w_old;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        redirect    = 1'b0;
        redirect_pc = w_base;
        case (r_state)
            ST_IDLE: begin
                if (w_mret) begin
                    redirect    = 1'b1;
                    redirect_pc = r_mepc;
                end else if (w_trap) begin
                    redirect    = 1'b1;
                    redirect_pc = r_mtvec_vec ? w_base + BUS_WIDTH'({w_cause, 2'b00}) : w_base;
                end
                if (redirect) w_state_nxt = ST_FLUSH;
            end
            ST_FLUSH: w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mie         <= 1'b0;
            r_mpie        <= 1'b0;
            r_irq_en      <= '0;
            r_mip         <= '0;
            r_irq_prev    <= '0;
            r_mtvec_base  <= MTVEC_RESET[BUS_WIDTH-1:2];
            r_mtvec_vec   <= (MTVEC_RESET[1:0] == 2'b01);
            r_mepc        <= '0;
            r_mcause_int  <= 1'b0;
            r_mcause_code <= '0;
            r_cyc_lo      <= '0;
            r_cyc_hi      <= '0;
        end else begin
            r_irq_prev <= irq_src;
            // Edge lines: a new rising edge beats the clear from the trap that consumes it.
            for (int i = 0; i < NUM_IRQ; i++) begin
                if (!IRQ_EDGE[i])                       r_mip[i] <= irq_src[i];
                else if (irq_src[i] && !r_irq_prev[i])  r_mip[i] <= 1'b1;
                else if (w_trap && (w_idx == 5'(i)))    r_mip[i] <= 1'b0;
            end

            if (w_trap) begin
                r_mpie        <= r_mie;
                r_mie         <= 1'b0;
                r_mepc        <= inst_pc;
                r_mcause_int  <= 1'b1;
                r_mcause_code <= w_cause;
            end else if (w_mret) begin
                r_mie  <= r_mpie;
                r_mpie <= 1'b1;
            end else if (w_wr && csr_addr == A_MSTATUS) begin
                r_mie  <= w_new[3];
                r_mpie <= w_new[7];
            end

            if (w_wr && csr_addr == A_MIE)
                for (int i = 0; i < NUM_IRQ; i++) r_irq_en[i] <= w_new[IRQ_BASE_CODE+i];
            if (w_wr && csr_addr == A_MTVEC) begin
                r_mtvec_base <= w_new[BUS_WIDTH-1:2];
                r_mtvec_vec  <= (w_new[1:0] == 2'b01);
            end
            if (w_wr && csr_addr == A_MEPC)
                r_mepc <= {w_new[BUS_WIDTH-1:2], 2'b00};
            if (w_wr && csr_addr == A_MCAUSE) begin
                r_mcause_int  <= w_new[BUS_WIDTH-1];
                r_mcause_code <= w_new[4:0];
            end

            if (w_wr && csr_addr == A_MCYCLE)       r_cyc_lo <= w_new;
            else if (w_wr && csr_addr == A_MCYCLEH) r_cyc_hi <= w_new;
            else                                    {r_cyc_hi, r_cyc_lo} <= w_cyc_inc;
        end
    end
endmodule

// File: tb/tb_csr_irq_ctrl.sv
// Self-checking bench for csr_irq_ctrl: CSR access, trap entry, mret, edge lines, mcycle wrap.
module tb_csr_irq_ctrl;
    localparam logic [11:0] A_MSTATUS = 12'h300, A_MIE = 12'h304, A_MTVEC = 12'h305;
    localparam logic [11:0] A_MEPC = 12'h341, A_MCAUSE = 12'h342, A_MIP = 12'h344;
    localparam logic [11:0] A_MCYCLE = 12'hB00, A_MCYCLEH = 12'hB80;

    logic        clk = 1'b0;
    logic        rst;
    logic        csr_rd_en, csr_wr_en, stage_valid, is_mret, redirect;
    logic [1:0]  csr_op;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata, csr_rdata, inst_pc, redirect_pc;
    logic [3:0]  irq_src;

    logic [31:0] exp_q[$];
    logic [31:0] exp_v, rd;
    int          n_checks = 0;
    int          n_err = 0;

    csr_irq_ctrl #(
        .BUS_WIDTH(32), .NUM_IRQ(4), .IRQ_BASE_CODE(16),
        .IRQ_EDGE(4'b1000), .MTVEC_RESET(32'h0)
    ) dut (
        .clk(clk), .rst(rst),
        .csr_rd_en(csr_rd_en), .csr_wr_en(csr_wr_en), .csr_op(csr_op),
        .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
        .irq_src(irq_src), .stage_valid(stage_valid), .inst_pc(inst_pc),
        .is_mret(is_mret), .redirect(redirect), .redirect_pc(redirect_pc)
    );

    // Clock and reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Driver tasks: every task starts and ends just after a falling edge.
    task automatic csr_write(input logic [11:0] a, input logic [1:0] op, input logic [31:0] d);
        csr_wr_en = 1'b1; csr_op = op; csr_addr = a; csr_wdata = d;
        @(negedge clk);
        csr_wr_en = 1'b0; csr_op = 2'b00; csr_wdata = '0;
    endtask

    task automatic csr_read(input logic [11:0] a, output logic [31:0] d);
        csr_rd_en = 1'b1; csr_addr = a;
        #1 d = csr_rdata;
        @(negedge clk);
        csr_rd_en = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; csr_rd_en = 0; csr_wr_en = 0; csr_op = 0; csr_addr = 0;
        csr_wdata = 0; irq_src = 0; stage_valid = 0; inst_pc = 0; is_mret = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        exp_q.push_back(32'd3);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h1800);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        csr_read(A_MCYCLE, rd); exp_v = exp_q.pop_front(); n_checks++;
        if (rd !== exp_v) begin n_err++; $display("FAIL rst_mcycle: got %h want %h", rd, exp_v); end
        csr_read(A_MCYCLEH, rd); exp_v = exp_q.pop_front(); n_checks++;
        if (rd !== exp_v) begin n_err++; $display("FAIL rst_mcycleh: got %h want %h", rd, exp_v); end
        csr_read(A_MSTATUS, rd); exp_v = exp_q.pop_front(); n_checks++;
        if (rd !== exp_v) begin n_err++; $display("FAIL rst_mstatus: got %h want %h", rd, exp_v); end
        csr_read(A_MIE, rd); exp_v = exp_q.pop_front(); n_checks++;
        if (rd !== exp_v) begin n_err++; $display("FAIL rst_mie: got %h want %h", rd, exp_v); end
        csr_read(A_MIP, rd); exp_v = exp_q.pop_front(); n_checks++;
        if (rd !== exp_v) begin n_err++; $display("FAIL rst_mip: got %h want %h", rd, exp_v); end
        csr_read(A_MTVEC, rd); exp_v = exp_q.pop_front(); n_checks++;
        if (rd !== exp_v) begin n_err++; $display("FAIL rst_mtvec: got %h want %h", rd, exp_v); end
        csr_read(A_MEPC, rd); exp_v = exp_q.pop_front(); n_checks++;
        if (rd !== exp_v) begin n_err++; $display("FAIL rst_mepc: got %h want %h", rd, exp_v); end
        csr_read(A_MCAUSE, rd); exp_v = exp_q.pop_front(); n_checks++;
        if (rd !== exp_v) begin n_err++; $display("FAIL rst_mcause: got %h want %h", rd, exp_v); end
        n_checks++;
        if (redirect !== 1'b0) begin n_err++; $display("FAIL rst_redirect: got %b want 0", redirect); end
    endtask

    task automatic test_csr_fields();
        csr_write(A_MTVEC, 2'b01, 32'h303); exp_q.push_back(32'h300);
        csr_read(A_MTVEC, rd); exp_v = exp_q.pop_front(); n_checks++;
        if (rd !== exp_v) begin n_err++; $display("FAIL mtvec_bad_mode: got %h want %h", rd, exp_v); end
        csr_write(A_MTVEC, 2'b01, 32'h105); exp_q.push_back(32'h105);
        csr_read(A_MTVEC, rd); exp_v = exp_q.pop_front(); n_checks++;
        if (rd !== exp_v) begin n_err++; $display("FAIL mtvec_vec_mode: got %h want %h", rd, exp_v); end
        csr_write(A_MEPC, 2'b01, 32'h43); exp_q.push_back(32'h40);
        csr_read(A_MEPC, rd); exp_v = exp_q.pop_front(); n_checks++;
        if (rd !== exp_v) begin n_err++; $display("FAIL mepc_align: got %h want %h", rd, exp_v); end
        csr_write(A_MCAUSE, 2'b01, 32'hFFFF_FFFF); exp_q.push_back(32'h8000_001F);
        csr_read(A_MCAUSE, rd); exp_v = exp_q.pop_front(); n_checks++;
        if (rd !== exp_v) begin n_err++; $display("FAIL mcause_mask: got %h want %h", rd, exp_v); end
        csr_write(A_MIP, 2'b01, 32'hFFFF_FFFF); exp_q.push_back(32'h0);
        csr_read(A_MIP, rd); exp_v = exp_q.pop_front(); n_checks++;
        if (rd !== exp_v) begin n_err++; $display("FAIL mip_readonly: got %h want %h", rd, exp_v); end
        csr_write(A_MIE, 2'b10, 32'hFFFF_FFFF); exp_q.push_back(32'h000F_0000);
        csr_read(A_MIE, rd); exp_v = exp_q.pop_front(); n_checks++;
        if (rd !== exp_v) begin n_err++; $display("FAIL mie_set: got %h want %h", rd, exp_v); end
        csr_write(A_MIE, 2'b11, 32'h0003_0000); exp_q.push_back(32'h000C_0000);
        csr_read(A_MIE, rd); exp_v = exp_q.pop_front(); n_checks++;
        if (rd !== exp_v) begin n_err++; $display("FAIL mie_clear: got %h want %h", rd, exp_v); end
        csr_write(A_MIE, 2'b01, 32'h0);
        csr_addr = A_MSTATUS; #1 n_checks++;
        if (csr_rdata !== 32'h0) begin n_err++; $display("FAIL rd_en_low: got %h want 0", csr_rdata); end
        csr_rd_en = 1'b1; csr_addr = 12'h7C0; #1 n_checks++;
        if (csr_rdata !== 32'h0) begin n_err++; $display("FAIL unimpl_addr: got %h want 0", csr_rdata); end
        @(negedge clk); csr_rd_en = 1'b0;
    endtask

    task automatic test_direct();
        csr_write(A_MTVEC, 2'b01, 32'h100);
        csr_write(A_MIE, 2'b01, 32'h0001_0000);
        csr_write(A_MSTATUS, 2'b10, 32'h8);
        irq_src = 4'b0001;
        #1 n_checks++;
        if (redirect !== 1'b0) begin n_err++; $display("FAIL direct_early: got %b want 0", redirect); end
        @(negedge clk);
        stage_valid = 1'b1; inst_pc = 32'h40;
        #1 n_checks++;
        if (redirect !== 1'b1 || redirect_pc !== 32'h100) begin
            n_err++; $display("FAIL direct_redirect: got %b/%h want 1/00000100", redirect, redirect_pc);
        end
        @(negedge clk); stage_valid = 1'b0;
        exp_q.push_back(32'h40); exp_q.push_back(32'h8000_0010); exp_q.push_back(32'h1880);
        csr_read(A_MEPC, rd); exp_v = exp_q.pop_front(); n_checks++;
        if (rd !== exp_v) begin n_err++; $display("FAIL direct_mepc: got %h want %h", rd, exp_v); end
        csr_read(A_MCAUSE, rd); exp_v = exp_q.pop_front(); n_checks++;
        if (rd !== exp_v) begin n_err++; $display("FAIL direct_mcause: got %h want %h", rd, exp_v); end
        csr_read(A_MSTATUS, rd); exp_v = exp_q.pop_front(); n_checks++;
        if (rd !== exp_v) begin n_err++; $display("FAIL direct_mstatus: got %h want %h", rd, exp_v); end
    endtask

    task automatic test_vectored_mret();
        irq_src = 4'b0000;
        csr_write(A_MTVEC, 2'b01, 32'h201);
        csr_write(A_MIE, 2'b01, 32'h0007_0000);
        irq_src = 4'b0110;
        csr_write(A_MSTATUS, 2'b10, 32'h8);
        stage_valid = 1'b1; inst_pc = 32'h80;
        #1 n_checks++;
        if (redirect !== 1'b1 || redirect_pc !== 32'h244) begin
            n_err++; $display("FAIL vec_redirect: got %b/%h want 1/00000244", redirect, redirect_pc);
        end
        @(negedge clk); stage_valid = 1'b0;
        exp_q.push_back(32'h8000_0011);
        csr_read(A_MCAUSE, rd); exp_v = exp_q.pop_front(); n_checks++;
        if (rd !== exp_v) begin n_err++; $display("FAIL vec_mcause: got %h want %h", rd, exp_v); end
        stage_valid = 1'b1; is_mret = 1'b1;
        #1 n_checks++;
        if (redirect !== 1'b1 || redirect_pc !== 32'h80) begin
            n_err++; $display("FAIL mret_redirect: got %b/%h want 1/00000080", redirect, redirect_pc);
        end
        @(negedge clk); is_mret = 1'b0; inst_pc = 32'h90;
        csr_rd_en = 1'b1; csr_addr = A_MSTATUS;
        #1 n_checks++;
        if (redirect !== 1'b0) begin n_err++; $display("FAIL flush_no_trap: got %b want 0", redirect); end
        n_checks++;
        if (csr_rdata !== 32'h1888) begin n_err++; $display("FAIL mret_mstatus: got %h want 00001888", csr_rdata); end
        @(negedge clk); csr_rd_en = 1'b0;
        #1 n_checks++;
        if (redirect !== 1'b1 || redirect_pc !== 32'h244) begin
            n_err++; $display("FAIL retrap: got %b/%h want 1/00000244", redirect, redirect_pc);
        end
        @(negedge clk); stage_valid = 1'b0;
    endtask

    task automatic test_edge();
        irq_src = 4'b0000;
        csr_write(A_MIE, 2'b01, 32'h0008_0000);
        irq_src = 4'b1000;
        @(negedge clk); irq_src = 4'b0000;
        repeat (2) @(negedge clk);
        exp_q.push_back(32'h0008_0000);
        csr_read(A_MIP, rd); exp_v = exp_q.pop_front(); n_checks++;
        if (rd !== exp_v) begin n_err++; $display("FAIL edge_held: got %h want %h", rd, exp_v); end
        csr_write(A_MSTATUS, 2'b10, 32'h8);
        stage_valid = 1'b1; inst_pc = 32'hA0;
        #1 n_checks++;
        if (redirect !== 1'b1 || redirect_pc !== 32'h24C) begin
            n_err++; $display("FAIL edge_redirect: got %b/%h want 1/0000024c", redirect, redirect_pc);
        end
        @(negedge clk); stage_valid = 1'b0;
        exp_q.push_back(32'h0); exp_q.push_back(32'h8000_0013);
        csr_read(A_MIP, rd); exp_v = exp_q.pop_front(); n_checks++;
        if (rd !== exp_v) begin n_err++; $display("FAIL edge_cleared: got %h want %h", rd, exp_v); end
        csr_read(A_MCAUSE, rd); exp_v = exp_q.pop_front(); n_checks++;
        if (rd !== exp_v) begin n_err++; $display("FAIL edge_mcause: got %h want %h", rd, exp_v); end
        stage_valid = 1'b1; is_mret = 1'b1;
        @(negedge clk); stage_valid = 1'b0; is_mret = 1'b0;
        @(negedge clk);
        irq_src = 4'b1000;
        @(negedge clk);
        irq_src = 4'b0000; stage_valid = 1'b1; inst_pc = 32'hB0;
        csr_wr_en = 1'b1; csr_op = 2'b11; csr_addr = A_MSTATUS; csr_wdata = 32'h88;
        #1 n_checks++;
        if (redirect !== 1'b1) begin n_err++; $display("FAIL trap_vs_csrrc: got %b want 1", redirect); end
        @(negedge clk);
        stage_valid = 1'b0; csr_wr_en = 1'b0; csr_op = 2'b00; csr_wdata = '0;
        exp_q.push_back(32'h1880); exp_q.push_back(32'hB0);
        csr_read(A_MSTATUS, rd); exp_v = exp_q.pop_front(); n_checks++;
        if (rd !== exp_v) begin n_err++; $display("FAIL csrrc_dropped: got %h want %h", rd, exp_v); end
        csr_read(A_MEPC, rd); exp_v = exp_q.pop_front(); n_checks++;
        if (rd !== exp_v) begin n_err++; $display("FAIL csrrc_mepc: got %h want %h", rd, exp_v); end
    endtask

    task automatic test_mcycle_wrap();
        csr_write(A_MCYCLEH, 2'b01, 32'hFFFF_FFFF);
        csr_write(A_MCYCLE, 2'b01, 32'hFFFF_FFFE);
        exp_q.push_back(32'hFFFF_FFFE); exp_q.push_back(32'hFFFF_FFFF);
        exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        csr_read(A_MCYCLE, rd); exp_v = exp_q.pop_front(); n_checks++;
        if (rd !== exp_v) begin n_err++; $display("FAIL wrap_lo_written: got %h want %h", rd, exp_v); end
        csr_read(A_MCYCLEH, rd); exp_v = exp_q.pop_front(); n_checks++;
        if (rd !== exp_v) begin n_err++; $display("FAIL wrap_hi_before: got %h want %h", rd, exp_v); end
        csr_read(A_MCYCLE, rd); exp_v = exp_q.pop_front(); n_checks++;
        if (rd !== exp_v) begin n_err++; $display("FAIL wrap_lo_zero: got %h want %h", rd, exp_v); end
        csr_read(A_MCYCLEH, rd); exp_v = exp_q.pop_front(); n_checks++;
        if (rd !== exp_v) begin n_err++; $display("FAIL wrap_hi_zero: got %h want %h", rd, exp_v); end
    endtask

    task automatic test_reset_mid_handler();
        irq_src = 4'b0001;
        csr_write(A_MIE, 2'b01, 32'h0001_0000);
        csr_write(A_MSTATUS, 2'b10, 32'h8);
        stage_valid = 1'b1; inst_pc = 32'hC0;
        #1 n_checks++;
        if (redirect !== 1'b1) begin n_err++; $display("FAIL pre_reset_trap: got %b want 1", redirect); end
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        csr_rd_en = 1'b1; csr_addr = A_MSTATUS;
        #1 n_checks++;
        if (redirect !== 1'b0) begin n_err++; $display("FAIL post_reset_redirect: got %b want 0", redirect); end
        n_checks++;
        if (csr_rdata !== 32'h1800) begin n_err++; $display("FAIL post_reset_mstatus: got %h want 00001800", csr_rdata); end
        @(negedge clk); csr_rd_en = 1'b0; stage_valid = 1'b0;
        exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        csr_read(A_MEPC, rd); exp_v = exp_q.pop_front(); n_checks++;
        if (rd !== exp_v) begin n_err++; $display("FAIL post_reset_mepc: got %h want %h", rd, exp_v); end
        csr_read(A_MTVEC, rd); exp_v = exp_q.pop_front(); n_checks++;
        if (rd !== exp_v) begin n_err++; $display("FAIL post_reset_mtvec: got %h want %h", rd, exp_v); end
        csr_read(A_MIE, rd); exp_v = exp_q.pop_front(); n_checks++;
        if (rd !== exp_v) begin n_err++; $display("FAIL post_reset_mie: got %h want %h", rd, exp_v); end
    endtask

    initial begin
        do_reset();
        test_reset();
        test_csr_fields();
        test_direct();
        test_vectored_mret();
        test_edge();
        test_mcycle_wrap();
        test_reset_mid_handler();
        n_checks++;
        if (exp_q.size() != 0) begin n_err++; $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size()); end
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/csr_irq_ctrl.md
# csr_irq_ctrl

Parametrised machine-mode CSR and interrupt controller for the 3-stage pipeline, with NUM_IRQ external interrupt lines. Each line can be level- or edge-sensitive. Pending sources are resolved by fixed priority, and the block supports direct and vectored mtvec modes, mret with MIE/MPIE stacking, and a 64-bit mcycle counter. It sits beside the writeback stage, takes CSR accesses from the execute/writeback boundary, and returns a redirect PC and pulse to fetch.

## Interface
- BUS_WIDTH, 32, data/PC width.
- NUM_IRQ, 4, number of interrupt lines, 1..16.
- IRQ_BASE_CODE, 16, cause code and mip/mie bit of line 0; IRQ_BASE_CODE+NUM_IRQ <= BUS_WIDTH-1.
- IRQ_EDGE, '0, NUM_IRQ-bit mask; bit set = line i is rising-edge latched, clear = level.
- MTVEC_RESET, 32'h0, mtvec reset value.
- clk  in  1  clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- csr_rd_en  in  1  CSR read this cycle.
- csr_wr_en  in  1  CSR write this cycle.
- csr_op  in  2  01 write, 10 set, 11 clear; 00 = no write.
- csr_addr  in  12  CSR address.
- csr_wdata  in  BUS_WIDTH  rs1 value or zero-extended uimm, already selected upstream.
- csr_rdata  out  BUS_WIDTH  read data, combinational; 0 when csr_rd_en=0 or address unimplemented.
- irq_src  in  NUM_IRQ  interrupt requests, synchronous to clk.
- stage_valid  in  1  writeback instruction is valid (not a bubble).
- inst_pc  in  BUS_WIDTH  PC of the writeback instruction.
- is_mret  in  1  writeback instruction is mret.
- redirect  out  1  one-cycle pulse: fetch must jump to redirect_pc and flush younger instructions.
- redirect_pc  out  BUS_WIDTH  trap vector or mepc.

## Operation
- Implemented CSRs:
  - mstatus 0x300: MIE[3], MPIE[7], MPP[12:11] reads 2'b11; all other bits read 0.
  - mie 0x304 and mip 0x344: only bits IRQ_BASE_CODE+i are implemented. mip is read-only and writes to it are ignored.
  - mtvec 0x305: base = wdata[BUS_WIDTH-1:2]; mode = wdata[1:0]. Mode 01 is stored; any other mode stores 00.
  - mepc 0x341: bits [1:0] forced to 0.
  - mcause 0x342: written value is masked to {bit31, low 5 bits}.
  - mcycle 0xB00 and mcycleh 0xB80: read/write.
- Write data per csr_op: write = wdata; set = old | wdata; clear = old & ~wdata.
- mip update, every cycle, per line i:
  - Level line: mip bit = irq_src[i] registered.
  - Edge line: mip bit is set on a 0->1 transition of irq_src[i] (previous sample held in a register). It clears only when a trap is taken for line i; a set in the same cycle as the clear wins.
- Pending vector = mip & mie. The lowest index wins.
- Trap condition: state IDLE, pending != 0, mstatus.MIE = 1, stage_valid = 1, is_mret = 0. On a trap:
  - mepc <= inst_pc; the instruction is not retired and its CSR write is suppressed.
  - mcause <= {1'b1, (IRQ_BASE_CODE+idx)} in 5 bits.
  - MPIE <= MIE; MIE <= 0.
  - Edge pending bit for idx is cleared.
  - redirect = 1; redirect_pc = base if mode 00, else base + 4*(IRQ_BASE_CODE+idx).
- mret (is_mret and stage_valid in state IDLE):
  - MIE <= MPIE; MPIE <= 1.
  - redirect = 1; redirect_pc = mepc.
  - mret takes priority over a simultaneous interrupt; the interrupt is re-evaluated after FLUSH.
- State machine:
  - IDLE -> FLUSH on any redirect.
  - FLUSH -> IDLE after exactly 1 cycle.
  - In FLUSH, redirect = 0, no trap is taken, and mret is ignored.
- mcycle:
  - 64-bit counter, +1 every cycle, wraps at 2^64.
  - A write to mcycle replaces the low word and a write to mcycleh replaces the high word. The increment is suppressed in the cycle of either write.

## Timing
- Reset values: mstatus MIE=0, MPIE=0; mie=0; mip=0; edge history=0; mtvec=MTVEC_RESET; mepc=0; mcause=0; mcycle=0; state IDLE; redirect=0.
- CSR write effects are visible on csr_rdata in the next cycle. Reads see the pre-write value in the same cycle.
- Interrupt latency: irq_src rises in cycle N -> mip bit set at end of N -> redirect asserted in N+1 if the trap condition holds. Architectural updates take effect at the end of N+1.
- redirect and redirect_pc are combinational from registered state and the current-cycle inputs, valid in the redirect cycle only.
- A write to mstatus.MIE=1 in cycle N allows a trap in N+1 at the earliest.
- Reset mid-handler returns every register to its reset value in the next cycle; no redirect is issued.

## Test plan
- Reset, then read all CSRs:
  - mstatus=0x1800, mtvec=MTVEC_RESET, all others 0.
  - mcycle reads 3 after 3 post-reset cycles.
- Direct mode, line 0, level:
  - Set mtvec=0x100, mie bit 16, MIE=1; raise irq_src[0] with inst_pc=0x40.
  - Required: redirect in the following cycle with redirect_pc=0x100; mepc=0x40; mcause=0x80000010; mstatus=0x1880.
- Vectored mode, simultaneous lines:
  - mtvec=0x201; raise lines 2 and 1 together.
  - Required: line 1 taken; redirect_pc=0x200+4*17=0x244.
- mret after a trap:
  - Required: redirect_pc = mepc; mstatus MIE=1, MPIE=1.
  - The still-pending level line traps again 2 cycles later, not during FLUSH.
- Edge line with IRQ_EDGE[3]=1:
  - Pulse irq_src[3] for 1 cycle while MIE=0: mip bit 19 stays set.
  - Enable MIE: trap taken and bit 19 cleared.
  - csrrc of MIE in the same cycle as a pending trap: trap wins and the write is dropped.
- mcycle wrap:
  - Write mcycleh=0xFFFFFFFF and mcycle=0xFFFFFFFE.
  - Required: two cycles later the counter reads 0 in both words.
